usb_serial_tx_arbiter: RTL and testbench
========================================

// Module: usb_serial_tx_arbiter
// PURPOSE
// - Shares the single TX byte FIFO of the USB serial FIFO-PHY between NREQ byte-stream requesters.
// - Round-robin arbitration with burst granularity: a grant holds until the requester drops valid or MAXBURST bytes are written.
// - Sits in the tx_clk_i domain, directly in front of tx_write_i/tx_data_i/tx_full_o of the FIFO-PHY.
// PARAMETERS
// - NREQ      2   number of requesters, 2..16
// - MAXBURST  64  max bytes per grant, 1..256; counter width clog2(MAXBURST)+1
// PORTS
// - clk_i       in   1       single clock; same as the PHY tx_clk_i
// - rst_i       in   1       synchronous, active-high reset
// - valid_i     in   NREQ    requester n has a byte on data_i[8n+7:8n]
// - data_i      in   8*NREQ  requester bytes, packed, requester 0 in bits [7:0]
// - rdy_o       out  NREQ    one-cycle pulse: requester n's byte consumed this cycle
// - grant_o     out  NREQ    one-hot current owner; 0 when idle
// - tx_write_o  out  1       to FIFO-PHY tx_write_i
// - tx_data_o   out  8       to FIFO-PHY tx_data_i
// - tx_full_i   in   1       from FIFO-PHY tx_full_o
// BEHAVIOUR
// - Reset: state IDLE, grant_o=0, rdy_o=0, tx_write_o=0, count=0, rr pointer=NREQ-1 (requester 0 has first priority).
// - All outputs derive from registered state; rdy_o, tx_write_o, tx_data_o are combinational from state/grant, valid_i, tx_full_i.
// - States: IDLE -> [TAG] -> BURST -> IDLE.
// - IDLE: search valid_i from (rr+1) mod NREQ upward, wrapping; first hit g is latched.
//   On the next edge: grant_o=1<<g, rr=g, count=0, state=TAG when tagging is enabled, else BURST. No valid: stay IDLE.
// - BURST, write condition valid_i[g] && !tx_full_i:
//   tx_write_o=1, tx_data_o=data_i[8g+:8], rdy_o[g]=1, count+=1.
//   Same-cycle handshake; requester presents its next byte on the following cycle.
// - BURST, stall: valid_i[g]=1 && tx_full_i=1 -> no write, no rdy_o, count holds, grant holds for any number of cycles.
// - BURST, release: valid_i[g]=0 in any cycle (full or not) -> no write; next state IDLE, grant_o=0.
// - BURST, limit: write that makes count==MAXBURST -> that byte is written; next state IDLE, grant_o=0.
// - Each release costs exactly one IDLE cycle before the next grant; back-to-back bursts have a 1-cycle gap (2 with TAG).
// - Non-granted requesters never see rdy_o; their valid_i/data_i are ignored.
// - valid_i must stay high with stable data until rdy_o; the block does not check this.
// - tx_data_o=0 whenever tx_write_o=0.
// - rst_i mid-burst: takes effect on that edge, with no further write.
//   A byte presented in the reset cycle is not consumed (rdy_o forced 0 while rst_i=1).
// - count never exceeds MAXBURST; MAXBURST=1 gives strict byte-wise round-robin.
// CONFIGURATION
// - USB_SERIAL_TX_ARBITER_TAG_EN defined: state TAG inserted after each grant.
//   TAG writes one byte {4'hF, g[3:0]} when !tx_full_i; it stalls while full; no rdy_o; count is not incremented.
//   TAG then enters BURST, even if valid_i[g] has dropped; BURST releases on the next cycle.
//   Purpose: lets the host demultiplex channels.
// - Undefined: TAG state and its logic are absent; IDLE goes straight to BURST.
// TESTING
// - Reset, then valid_i=2'b01, bytes 0x11,0x22,0x33, then valid low, tx_full_i=0
//   -> three tx_write_o pulses carrying 0x11,0x22,0x33; grant_o=01 then 00.
// - Both requesters continuously valid, MAXBURST=4
//   -> alternating bursts of 4 bytes: req0, req1, req0; 1-cycle gap between bursts; no byte lost or duplicated.
// - tx_full_i=1 for 5 cycles in the middle of a req1 burst
//   -> no writes and no rdy_o during the stall; count and grant_o=10 held; transfer resumes with the same byte.
// - rst_i asserted for 1 cycle after 2 bytes of a burst
//   -> next cycle grant_o=0, tx_write_o=0; arbitration restarts with requester 0 first.
// - MAXBURST=1, NREQ=4, all valid -> grant order 0,1,2,3,0, one byte each.
// - TAG_EN, NREQ=2, req1 sends 0xAB
//   -> FIFO receives 0xF1 then 0xAB; with tx_full_i=1 during TAG, 0xF1 is delayed, not dropped.

Source files
------------

// File: rtl/usb_serial_tx_arbiter.sv
// usb_serial_tx_arbiter
// Shares the single TX byte FIFO of the USB serial FIFO-PHY between NREQ
// byte-stream requesters. Arbitration is round-robin with burst granularity:
// a grant is held until the owner drops valid or MAXBURST bytes are written.
//
// Optional feature: define USB_SERIAL_TX_ARBITER_TAG_EN to insert a TAG state
// after every grant. It writes {4'hF, g[3:0]} so the host can demultiplex
// channels.
//
// Ports
//   clk_i       clock (same as PHY tx_clk_i)
//   rst_i       synchronous active-high reset
//   valid_i     per-requester byte valid
//   data_i      per-requester bytes, requester 0 in [7:0]
//   rdy_o       per-requester consume pulse (combinational)
//   grant_o     one-hot current owner, 0 when idle (registered)
//   tx_write_o  FIFO write strobe (combinational)
//   tx_data_o   FIFO write data, 0 when not writing (combinational)
//   tx_full_i   FIFO full
module usb_serial_tx_arbiter #(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned MAXBURST = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NREQ-1:0]     valid_i,
  input  logic [8*NREQ-1:0]   data_i,
  output logic [NREQ-1:0]     rdy_o,
  output logic [NREQ-1:0]     grant_o,
  output logic                tx_write_o,
  output logic [7:0]          tx_data_o,
  input  logic                tx_full_i
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(MAXBURST) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAXBURST);

`ifdef USB_SERIAL_TX_ARBITER_TAG_EN
  typedef enum logic [1:0] {ST_IDLE, ST_TAG, ST_BURST} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_BURST} state_t;
`endif

  state_t          r_state;
  logic [NREQ-1:0] r_grant;
  logic [IW-1:0]   r_rr;
  logic [CW-1:0]   r_count;

  state_t          w_state_nxt;
  logic [NREQ-1:0] w_grant_nxt;
  logic [IW-1:0]   w_rr_nxt;
  logic [CW-1:0]   w_count_nxt;

  logic            w_found;
  logic [IW-1:0]   w_pick;
  logic [IW-1:0]   w_cand;
  logic            w_sel_valid;
  logic [7:0]      w_sel_data;

  assign grant_o = r_grant;

  // Round-robin search starting just after the last owner, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      w_cand = IW'((32'(r_rr) + i) % NREQ);
      if (!w_found && valid_i[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  // Owner's valid/data, selected by the one-hot grant (zero when idle).
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    for (int unsigned n = 0; n < NREQ; n++) begin
      if (r_grant[n]) begin
        w_sel_valid = valid_i[n];
        w_sel_data  = data_i[8*n +: 8];
      end
    end
  end

  // Next-state and combinational handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr;
    w_count_nxt = r_count;
    tx_write_o  = 1'b0;
    tx_data_o   = '0;
    rdy_o       = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant_nxt = NREQ'(1) << w_pick;
          w_rr_nxt    = w_pick;
          w_count_nxt = '0;
`ifdef USB_SERIAL_TX_ARBITER_TAG_EN
          w_state_nxt = ST_TAG;
`else
          w_state_nxt = ST_BURST;
`endif
        end
      end

`ifdef USB_SERIAL_TX_ARBITER_TAG_EN
      // Channel tag byte; always proceeds to BURST once written.
      ST_TAG: begin
        if (!tx_full_i) begin
          tx_write_o  = 1'b1;
          tx_data_o   = {4'hF, 4'(r_rr)};
          w_state_nxt = ST_BURST;
        end
      end
`endif

      ST_BURST: begin
        if (!w_sel_valid) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
        end else if (!tx_full_i) begin
          tx_write_o  = 1'b1;
          tx_data_o   = w_sel_data;
          rdy_o       = r_grant;
          w_count_nxt = r_count + CW'(1);
          if (r_count + CW'(1) == MAX_CNT) begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase

    // A byte presented during reset is neither written nor consumed.
    if (rst_i) begin
      tx_write_o = 1'b0;
      tx_data_o  = '0;
      rdy_o      = '0;
    end
  end

  // State register; rr reset to NREQ-1 gives requester 0 first priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_rr    <= IW'(NREQ - 1);
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_rr    <= w_rr_nxt;
      r_count <= w_count_nxt;
    end
  end

endmodule

// File: tb/tb_usb_serial_tx_arbiter.sv
// Directed bench for usb_serial_tx_arbiter: a 2-requester instance with
// MAXBURST=4 and a 4-requester instance with MAXBURST=1.
module tb_usb_serial_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cnt0  = 0;
  int cnt1  = 0;
  logic [7:0] base1 = 8'h20;

  // Instance A: NREQ=2, MAXBURST=4
  logic        a_rst, a_full, a_wr;
  logic [1:0]  a_valid, a_rdy, a_grant;
  logic [15:0] a_data;
  logic [7:0]  a_txd;

  // Requester bytes advance only after a consumed byte's clock edge.
  assign a_data = {8'(base1 + 8'(cnt1)), 8'(8'h11 * 8'(cnt0 + 1))};

  usb_serial_tx_arbiter #(.NREQ(2), .MAXBURST(4)) u_dut_a (
    .clk_i      (clk),
    .rst_i      (a_rst),
    .valid_i    (a_valid),
    .data_i     (a_data),
    .rdy_o      (a_rdy),
    .grant_o    (a_grant),
    .tx_write_o (a_wr),
    .tx_data_o  (a_txd),
    .tx_full_i  (a_full)
  );

  // Instance B: NREQ=4, MAXBURST=1
  logic        b_rst, b_wr;
  logic [3:0]  b_valid, b_rdy, b_grant;
  logic [31:0] b_data;
  logic [7:0]  b_txd;

  assign b_data = 32'h43424140;

  usb_serial_tx_arbiter #(.NREQ(4), .MAXBURST(1)) u_dut_b (
    .clk_i      (clk),
    .rst_i      (b_rst),
    .valid_i    (b_valid),
    .data_i     (b_data),
    .rdy_o      (b_rdy),
    .grant_o    (b_grant),
    .tx_write_o (b_wr),
    .tx_data_o  (b_txd),
    .tx_full_i  (1'b0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive A at the falling edge, check just after, then advance the
  // requester byte counters after the rising edge if a byte was consumed.
  task automatic step_a(input string tag, input logic rst, input logic [1:0] vld,
                        input logic full, input logic [1:0] eg, input logic [1:0] er,
                        input logic ew, input logic [7:0] ed);
    logic [1:0] r;
    @(negedge clk);
    a_rst   = rst;
    a_valid = vld;
    a_full  = full;
    #1;
    chk({tag, ".grant"}, 32'(a_grant), 32'(eg));
    chk({tag, ".rdy"},   32'(a_rdy),   32'(er));
    chk({tag, ".wr"},    32'(a_wr),    32'(ew));
    chk({tag, ".data"},  32'(a_txd),   32'(ed));
    r = a_rdy;
    @(posedge clk);
    #1;
    if (r[0]) cnt0++;
    if (r[1]) cnt1++;
  endtask

  task automatic step_b(input string tag, input logic [3:0] vld, input logic [3:0] eg,
                        input logic ew, input logic [7:0] ed);
    @(negedge clk);
    b_valid = vld;
    #1;
    chk({tag, ".grant"}, 32'(b_grant), 32'(eg));
    chk({tag, ".rdy"},   32'(b_rdy),   32'(ew ? eg : 4'b0000));
    chk({tag, ".wr"},    32'(b_wr),    32'(ew));
    chk({tag, ".data"},  32'(b_txd),   32'(ed));
  endtask

  initial begin
    a_rst = 1'b1; a_valid = '0; a_full = 1'b0;
    b_rst = 1'b1; b_valid = '0;
`ifdef USB_SERIAL_TX_ARBITER_TAG_EN
    base1 = 8'hAB;
`endif

    step_a("reset", 1, 2'b00, 0, 2'b00, 2'b00, 0, 8'h00);

`ifdef USB_SERIAL_TX_ARBITER_TAG_EN
    // Tag byte F1 precedes req1's AB; held off (not dropped) while full.
    step_a("tag_idle",  0, 2'b10, 0, 2'b00, 2'b00, 0, 8'h00);
    step_a("tag_stall", 0, 2'b10, 1, 2'b10, 2'b00, 0, 8'h00);
    step_a("tag_stall", 0, 2'b10, 1, 2'b10, 2'b00, 0, 8'h00);
    step_a("tag_byte",  0, 2'b10, 0, 2'b10, 2'b00, 1, 8'hF1);
    step_a("tag_data",  0, 2'b10, 0, 2'b10, 2'b10, 1, 8'hAB);
    step_a("tag_rel",   0, 2'b00, 0, 2'b10, 2'b00, 0, 8'h00);
    step_a("tag_done",  0, 2'b00, 0, 2'b00, 2'b00, 0, 8'h00);
`else
    // Single requester, three bytes, then release.
    step_a("t1_idle", 0, 2'b01, 0, 2'b00, 2'b00, 0, 8'h00);
    step_a("t1_b0",   0, 2'b01, 0, 2'b01, 2'b01, 1, 8'h11);
    step_a("t1_b1",   0, 2'b01, 0, 2'b01, 2'b01, 1, 8'h22);
    step_a("t1_b2",   0, 2'b01, 0, 2'b01, 2'b01, 1, 8'h33);
    step_a("t1_rel",  0, 2'b00, 0, 2'b01, 2'b00, 0, 8'h00);
    step_a("t1_done", 0, 2'b00, 0, 2'b00, 2'b00, 0, 8'h00);
    step_a("t1_rst",  1, 2'b00, 0, 2'b00, 2'b00, 0, 8'h00);

    // Both valid: bursts of 4 alternating req0, req1, req0 with 1-cycle gaps.
    step_a("t2_idle", 0, 2'b11, 0, 2'b00, 2'b00, 0, 8'h00);
    for (int k = 0; k < 4; k++)
      step_a("t2_r0a", 0, 2'b11, 0, 2'b01, 2'b01, 1, 8'(8'h44 + 8'h11 * k));
    step_a("t2_gap1", 0, 2'b11, 0, 2'b00, 2'b00, 0, 8'h00);
    for (int k = 0; k < 4; k++)
      step_a("t2_r1", 0, 2'b11, 0, 2'b10, 2'b10, 1, 8'(8'h20 + k));
    step_a("t2_gap2", 0, 2'b11, 0, 2'b00, 2'b00, 0, 8'h00);
    for (int k = 0; k < 4; k++)
      step_a("t2_r0b", 0, 2'b11, 0, 2'b01, 2'b01, 1, 8'(8'h88 + 8'h11 * k));
    step_a("t2_done", 0, 2'b00, 0, 2'b00, 2'b00, 0, 8'h00);

    // req1 burst with a 5-cycle full stall; count must hold through it.
    step_a("t3_idle", 0, 2'b10, 0, 2'b00, 2'b00, 0, 8'h00);
    step_a("t3_b0",   0, 2'b10, 0, 2'b10, 2'b10, 1, 8'h24);
    step_a("t3_b1",   0, 2'b10, 0, 2'b10, 2'b10, 1, 8'h25);
    for (int k = 0; k < 5; k++)
      step_a("t3_stall", 0, 2'b10, 1, 2'b10, 2'b00, 0, 8'h00);
    step_a("t3_b2",   0, 2'b10, 0, 2'b10, 2'b10, 1, 8'h26);
    step_a("t3_b3",   0, 2'b10, 0, 2'b10, 2'b10, 1, 8'h27);
    step_a("t3_done", 0, 2'b00, 0, 2'b00, 2'b00, 0, 8'h00);

    // Reset mid-burst: byte not consumed, priority returns to requester 0.
    step_a("t4_idle", 0, 2'b01, 0, 2'b00, 2'b00, 0, 8'h00);
    step_a("t4_b0",   0, 2'b01, 0, 2'b01, 2'b01, 1, 8'hCC);
    step_a("t4_b1",   0, 2'b01, 0, 2'b01, 2'b01, 1, 8'hDD);
    step_a("t4_rst",  1, 2'b01, 0, 2'b01, 2'b00, 0, 8'h00);
    step_a("t4_post", 0, 2'b11, 0, 2'b00, 2'b00, 0, 8'h00);
    step_a("t4_r0",   0, 2'b11, 0, 2'b01, 2'b01, 1, 8'hEE);
    step_a("t4_rel",  0, 2'b00, 0, 2'b01, 2'b00, 0, 8'h00);
    step_a("t4_done", 0, 2'b00, 0, 2'b00, 2'b00, 0, 8'h00);

    // MAXBURST=1, 4 requesters all valid: strict byte-wise round-robin.
    @(negedge clk);
    b_rst = 1'b0;
    step_b("t5_idle", 4'b1111, 4'b0000, 0, 8'h00);
    for (int n = 0; n < 5; n++) begin
      step_b("t5_g",   4'b1111, 4'(1 << (n % 4)), 1, 8'(8'h40 + (n % 4)));
      step_b("t5_gap", 4'b1111, 4'b0000, 0, 8'h00);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
